// File: rtl/rgb_status_sequencer.sv
// Status-class to RGB light-pattern sequencer: turns health-monitor classes into
// timed breathe/blink/steady patterns and 3-bit per-channel levels for the PWM stage.
module rgb_status_sequencer #(
   parameter int TICK_DIV  = 1_000_000,
   parameter int SLOW_HALF = 8,
   parameter int FAST_HALF = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] status,
   input  logic       status_valid,
   input  logic       ack,
   output logic [2:0] color_r,
   output logic [2:0] color_g,
   output logic [2:0] color_b,
   output logic       alarm_active
);

   localparam int PW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int PH_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int PHW    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [PHW-1:0] SLOW_LAST = PHW'(SLOW_HALF - 1);
   localparam logic [PHW-1:0] FAST_LAST = PHW'(FAST_HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_NORMAL, S_WARN, S_ALARM, S_ALARM_ACK, S_FAULT
   } state_t;

   state_t         state_q, state_d, target;
   logic [PW-1:0]  pre_q;
   logic [PHW-1:0] ph_cnt_q;
   logic [PHW-1:0] half_last;
   logic           phase_q;
   logic [2:0]     level_q;
   logic           dir_up_q;
   logic           tick;
   logic           same_class;
   logic           restart;
   logic           blinking;
   logic [2:0]     color_r_d, color_g_d, color_b_d;
   logic           alarm_d;
   logic [2:0]     color_r_q, color_g_q, color_b_q;
   logic           alarm_q;

   assign tick      = (pre_q == PRE_LAST);
   assign blinking  = (state_q == S_WARN) || (state_q == S_ALARM) || (state_q == S_FAULT);
   assign half_last = (state_q == S_ALARM) ? FAST_LAST : SLOW_LAST;

   // ALARM and ALARM_ACK share a class, so a repeated alarm does not undo an acknowledge.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      target = S_IDLE;
      case (status)
         2'd0:    target = S_NORMAL;
         2'd1:    target = S_WARN;
         2'd2:    target = S_ALARM;
         default: target = S_FAULT;
      endcase
   end

   assign same_class = (state_q == target) ||
                       ((target == S_ALARM) && (state_q == S_ALARM_ACK));
   assign restart    = status_valid && !same_class;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (restart)                             state_d = target;
      else if (ack && (state_q == S_ALARM))    state_d = S_ALARM_ACK;
   end

   // Pattern timebase: everything restarts from zero on a class change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || restart) begin
         pre_q    <= '0;
         ph_cnt_q <= '0;
         phase_q  <= 1'b0;
         level_q  <= 3'd0;
         dir_up_q <= 1'b1;
      end else begin
         pre_q <= tick ? '0 : pre_q + PW'(1);
         if (tick && blinking) begin
            if (ph_cnt_q == half_last) begin
               ph_cnt_q <= '0;
               phase_q  <= ~phase_q;
            end else begin
               ph_cnt_q <= ph_cnt_q + PHW'(1);
            end
         end
         // Triangle 0..7..0: the endpoint step reverses direction so 7 and 0 last one tick.
         if (tick && (state_q == S_NORMAL)) begin
            if (dir_up_q) begin
               if (level_q == 3'd7) begin
                  level_q  <= 3'd6;
                  dir_up_q <= 1'b0;
               end else begin
                  level_q <= level_q + 3'd1;
               end
            end else begin
               if (level_q == 3'd0) begin
                  level_q  <= 3'd1;
                  dir_up_q <= 1'b1;
               end else begin
                  level_q <= level_q - 3'd1;
               end
            end
         end
      end
   end

   always_comb begin
      color_r_d = 3'd0;
      color_g_d = 3'd0;
      color_b_d = 3'd0;
      alarm_d   = 1'b0;
      case (state_q)
         S_NORMAL: color_g_d = level_q;
         S_WARN: if (!phase_q) begin
            color_r_d = 3'd7;
            color_g_d = 3'd3;
         end
         S_ALARM: begin
            alarm_d = 1'b1;
            if (!phase_q) color_r_d = 3'd7;
         end
         S_ALARM_ACK: color_r_d = 3'd3;
         S_FAULT: begin
            color_b_d = 3'd7;
            if (phase_q) begin
               color_r_d = 3'd7;
               color_g_d = 3'd7;
            end
         end
         default: ;
      endcase
   end

   // NOTE: only control/output flops need reset; there is no memory here to leave unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         color_r_q <= 3'd0;
         color_g_q <= 3'd0;
         color_b_q <= 3'd0;
         alarm_q   <= 1'b0;
      end else begin
         color_r_q <= color_r_d;
         color_g_q <= color_g_d;
         color_b_q <= color_b_d;
         alarm_q   <= alarm_d;
      end
   end

   assign color_r      = color_r_q;
   assign color_g      = color_g_q;
   assign color_b      = color_b_q;
   assign alarm_active = alarm_q;

endmodule

// File: tb/tb_rgb_status_sequencer.sv
// Scoreboard bench for rgb_status_sequencer: a time-based reference model queues the
// expected outputs each edge; a monitor pops and compares them every cycle.
module tb_rgb_status_sequencer;

   localparam int TD   = 4;
   localparam int SLOW = 3;
   localparam int FAST = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] status;
   logic       status_valid;
   logic       ack;
   logic [2:0] color_r, color_g, color_b;
   logic       alarm_active;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_q[$];
   int         m_cls;
   bit         m_acked;
   int         ecount;
   int         entry;

   rgb_status_sequencer #(
      .TICK_DIV (TD),
      .SLOW_HALF(SLOW),
      .FAST_HALF(FAST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .status      (status),
      .status_valid(status_valid),
      .ack         (ack),
      .color_r     (color_r),
      .color_g     (color_g),
      .color_b     (color_b),
      .alarm_active(alarm_active)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] outs();
      return {alarm_active, color_r, color_g, color_b};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got {alarm,r,g,b}=%b_%0d_%0d_%0d expected %b_%0d_%0d_%0d",
                  name, $time, act[9], act[8:6], act[5:3], act[2:0],
                  exp[9], exp[8:6], exp[5:3], exp[2:0]);
      end
   endtask

   // Expected pattern for class cls having spent n whole ticks in it.
   function automatic logic [9:0] pattern(input int cls, input bit acked, input int n);
      int p;
      int lvl;
      bit ph;
      case (cls)
         0: begin
            p   = n % 14;
            lvl = (p <= 7) ? p : 14 - p;
            return {1'b0, 3'd0, 3'(lvl), 3'd0};
         end
         1: begin
            ph = ((n / SLOW) % 2) == 1;
            return ph ? 10'd0 : {1'b0, 3'd7, 3'd3, 3'd0};
         end
         2: begin
            if (acked) return {1'b0, 3'd3, 3'd0, 3'd0};
            ph = ((n / FAST) % 2) == 1;
            return {1'b1, ph ? 3'd0 : 3'd7, 3'd0, 3'd0};
         end
         3: begin
            ph = ((n / SLOW) % 2) == 1;
            return ph ? {1'b0, 3'd7, 3'd7, 3'd7} : {1'b0, 3'd0, 3'd0, 3'd7};
         end
         default: return 10'd0;
      endcase
   endfunction

   // Reference model: the expectation pushed at edge m is what the outputs show after edge m+1.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_cls   = -1;
            m_acked = 1'b0;
            ecount  = 0;
            entry   = 0;
            exp_q.delete();
            exp_q.push_back(10'd0);
         end else begin
            ecount++;
            if (status_valid && int'(status) != m_cls) begin
               m_cls   = int'(status);
               m_acked = 1'b0;
               entry   = ecount;
            end else if (ack && m_cls == 2) begin
               m_acked = 1'b1;
            end
            exp_q.push_back(pattern(m_cls, m_acked, (ecount - entry) / TD));
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("reset_outputs", outs(), 10'd0);
         end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty t=%0t got no expectation queued", $time);
         end else begin
            check("pattern", outs(), exp_q.pop_front());
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [1:0] s, input logic a);
      @(negedge clk);
      status       = s;
      status_valid = 1'b1;
      ack          = a;
      @(negedge clk);
      status_valid = 1'b0;
      ack          = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      status       = 2'd0;
      status_valid = 1'b0;
      ack          = 1'b0;
      wait_cycles(3);
      #2 rst = 1'b1;
      wait_cycles(50);

      send(2'd1, 1'b0);
      wait_cycles(40);

      send(2'd2, 1'b0);
      wait_cycles(20);
      pulse_ack();
      wait_cycles(10);
      send(2'd2, 1'b0);
      wait_cycles(10);

      send(2'd0, 1'b0);
      wait_cycles(70);

      send(2'd2, 1'b0);
      wait_cycles(6);
      send(2'd3, 1'b1);
      wait_cycles(30);
      pulse_ack();
      wait_cycles(10);

      send(2'd2, 1'b0);
      wait_cycles(5);
      send(2'd2, 1'b1);
      wait_cycles(10);

      send(2'd1, 1'b0);
      wait_cycles(15);
      #2 rst = 1'b0;
      #1 check("async_reset", outs(), 10'd0);
      wait_cycles(4);
      #2 rst = 1'b1;
      wait_cycles(50);
      send(2'd3, 1'b0);
      wait_cycles(20);

      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         status       = 2'($urandom_range(0, 3));
         status_valid = ($urandom_range(0, 15) == 0);
         ack          = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      status_valid = 1'b0;
      ack          = 1'b0;
      wait_cycles(3);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rgb_status_sequencer.md
Name: rgb_status_sequencer

Overview:
- Drives the 3-bit per-channel color inputs of the RGB PWM stage from the health monitor's status classification.
- Maps each status class to a timed light pattern: breathe, blink, steady or alternate.
- Handles alarm acknowledgement.
- Sits between the status/decision logic and the RGB PWM driver. It owns all pattern timing; the PWM stage only renders levels.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per pattern tick (≥2).
- SLOW_HALF, 8, ticks per half-period of slow patterns (≥1).
- FAST_HALF, 2, ticks per half-period of fast patterns (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- status  in  2  status class: 0 normal, 1 warning, 2 alarm, 3 sensor fault
- status_valid  in  1  one-cycle strobe; status sampled when high
- ack  in  1  one-cycle alarm acknowledge pulse
- color_r  out  3  red level to PWM stage
- color_g  out  3  green level to PWM stage
- color_b  out  3  blue level to PWM stage
- alarm_active  out  1  high in ALARM (unacknowledged) only

Behaviour:
- One clock; reset is asynchronous and active-low (rst low resets immediately, independent of clk).
- Reset values:
  - FSM = IDLE.
  - Prescaler, phase counter, breathe level = 0; breathe direction = up.
  - color_r/g/b = 0; alarm_active = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when the count equals TICK_DIV-1.
- FSM states: IDLE, NORMAL, WARN, ALARM, ALARM_ACK, FAULT.
  - IDLE: outputs 0 until the first status_valid.
- Transitions on status_valid, by class of status:
  - 0 → NORMAL, 1 → WARN, 2 → ALARM, 3 → FAULT.
  - If the target class equals the current class, there is no transition and no timer restart. ALARM and ALARM_ACK count as the same class, so a repeated alarm status keeps ALARM_ACK.
  - On a class change: prescaler, phase counter, phase bit, breathe level and breathe direction all reset.
- ack:
  - ALARM → ALARM_ACK.
  - Ignored in every other state.
  - If ack and a class-changing status_valid arrive in the same cycle, status_valid wins and ack is dropped. Otherwise ack applies.
- Phase timing:
  - The phase counter increments on each tick.
  - When it reaches half-1 (SLOW_HALF-1 or FAST_HALF-1 per state), the phase bit toggles and the counter clears.
  - Phase bit = 0 after entry.
- Pattern per state (r,g,b):
  - NORMAL: breathe (0,L,0). L steps ±1 per tick: up 0→7, then down 7→0, then repeats. Direction flips at 7 and 0, and each endpoint is held for exactly one tick.
  - WARN: phase 0 = (7,3,0), phase 1 = (0,0,0); SLOW_HALF.
  - ALARM: phase 0 = (7,0,0), phase 1 = (0,0,0); FAST_HALF.
  - ALARM_ACK: steady (3,0,0).
  - FAULT: phase 0 = (0,0,7), phase 1 = (7,7,7); SLOW_HALF.
  - IDLE: (0,0,0).
- Latency and output timing:
  - All outputs are registered.
  - Colors reflect the state/phase/level one clk after it changes. A status_valid at edge N gives new-pattern colors visible after edge N+1.
  - alarm_active is registered with the same latency.
- Level range: 3-bit values only; no overflow is possible, because the breathe level is clamped by the direction flip.

Test Plan:
Bench parameters: TICK_DIV=4, SLOW_HALF=3, FAST_HALF=1.
- Reset → all colors 0 and alarm_active 0. Release rst with no status_valid for 50 cycles → outputs stay 0 (IDLE).
- status=1 pulse → (7,3,0) two edges later, toggles to 0 every 12 cycles, first toggle 12 cycles after entry.
- status=2 pulse → (7,0,0)/off alternating every 4 cycles, alarm_active=1. Then ack pulse → steady (3,0,0) and alarm_active=0. Repeated status=2 → stays (3,0,0).
- status=0 pulse → green steps 0,1,…,7,6,…,0,1 changing every 4 cycles; r=b=0 throughout.
- In ALARM, status=3 and ack in the same cycle → FAULT: (0,0,7) then (7,7,7) after 12 cycles; alarm_active=0. A later ack → no effect.
- Assert rst mid-WARN blink → outputs 0 immediately, without a clock edge; after release, the FSM is IDLE until the next status_valid.
